// File: rtl/serial_addsub_if.sv
// Operand/result bundle for the digit-serial adder/subtractor.
// The master drives the request side and the slave returns the result and handshake flags.
interface serial_addsub_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic             mode;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Kin;
  logic [WIDTH-1:0] D;
  logic             Kout;
  logic             ovf;
  logic             zero;
  logic             busy;
  logic             done;

  modport master (
    output start, mode, A, B, Kin,
    input  D, Kout, ovf, zero, busy, done
  );

  modport slave (
    input  start, mode, A, B, Kin,
    output D, Kout, ovf, zero, busy, done
  );
endinterface

// File: rtl/serial_addsub.sv
// Digit-serial adder/subtractor: one DIGIT-bit slice per clock, LSB slice first.
// Subtraction is A + ~B + ~Kin, so the borrow-out is the inverted final carry.
module serial_addsub #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 2
) (
  input logic           clk,
  input logic           rst_n,
  serial_addsub_if.slave bus
);

  localparam int N     = WIDTH / DIGIT;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

  if (DIGIT < 1 || DIGIT > WIDTH || (WIDTH % DIGIT) != 0) begin : g_bad_digit
    $error("serial_addsub: DIGIT must divide WIDTH and lie in 1..WIDTH");
  end

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [WIDTH-1:0]   a_sh;
  logic [WIDTH-1:0]   b_sh;
  logic [WIDTH-1:0]   r_sh;
  logic               mode_r;
  logic               c_r;
  logic               sa_r;
  logic               sb_r;

  logic [DIGIT-1:0]       b_dig;
  logic [DIGIT:0]         sum;
  logic [WIDTH+DIGIT-1:0] cat;
  logic [WIDTH-1:0]       r_next;
  logic                   last;

  // Signed overflow from operand signs and result sign; sub compares A against -B.
  function automatic logic ovf_of(input logic sub, input logic sa, input logic sb,
                                  input logic sd);
    if (sub) return (sa != sb) && (sd != sa);
    else     return (sa == sb) && (sd != sa);
  endfunction

  always_comb begin
    b_dig  = mode_r ? ~b_sh[DIGIT-1:0] : b_sh[DIGIT-1:0];
    sum    = {1'b0, a_sh[DIGIT-1:0]} + {1'b0, b_dig} + {{DIGIT{1'b0}}, c_r};
    cat    = {sum[DIGIT-1:0], r_sh};
    r_next = cat[WIDTH+DIGIT-1:DIGIT];
    last   = (cnt == CNT_W'(N - 1));
  end

  // Working registers: loaded at start, shifted one slice per RUN cycle
  always_ff @(posedge clk) begin
    if (state == IDLE && bus.start) begin
      a_sh   <= bus.A;
      b_sh   <= bus.B;
      mode_r <= bus.mode;
      c_r    <= bus.mode ? ~bus.Kin : bus.Kin;
      sa_r   <= bus.A[WIDTH-1];
      sb_r   <= bus.B[WIDTH-1];
    end else if (state == RUN) begin
      a_sh <= a_sh >> DIGIT;
      b_sh <= b_sh >> DIGIT;
      r_sh <= r_next;
      c_r  <= sum[DIGIT];
    end
  end

  // Control FSM with registered handshake and result outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      bus.D    <= '0;
      bus.Kout <= 1'b0;
      bus.ovf  <= 1'b0;
      bus.zero <= 1'b0;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          bus.done <= 1'b0;
          if (bus.start) begin
            state    <= RUN;
            cnt      <= '0;
            bus.busy <= 1'b1;
          end
        end
        RUN: begin
          if (last) begin
            state    <= DONE;
            bus.done <= 1'b1;
            bus.D    <= r_next;
            bus.Kout <= mode_r ? ~sum[DIGIT] : sum[DIGIT];
            bus.ovf  <= ovf_of(mode_r, sa_r, sb_r, sum[DIGIT-1]);
            bus.zero <= (r_next == '0);
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        DONE: begin
          state    <= IDLE;
          bus.done <= 1'b0;
          bus.busy <= 1'b0;
        end
        default: begin
          state    <= IDLE;
          bus.done <= 1'b0;
          bus.busy <= 1'b0;
        end
      endcase
    end
  end

endmodule
